adi_spi_master_param: RTL and testbench

//  Parametrised ADI-style 3-wire SPI master; successor to the fixed 7-bit-addr/8-bit-data driver.

---
 rtl/adi_spi_master_param.sv | 209 ++++++++++++++++++++
 tb/tb_adi_spi_master_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adi_spi_master_param.sv
// ADI-style SPI master: INSTR_W-bit instruction followed by a burst of 1..MAX_BYTES data bytes per CS frame.
// Build option ADI_SPI_4WIRE_EN adds a separate sdo input and keeps sdio driven for the whole frame.
//
// state | meaning
// IDLE  | scb high, waiting for a write/read request
// INSTR | shifting out {rw, addr}, MSB first
// DATA  | shifting 8*len data bits (out on write, in on read)
// GAP   | scb high for CS_GAP*DIV clocks before the next accept
module adi_spi_master_param #(
   parameter int  CLK_FRE   = 100_000_000,
   parameter int  SCLK_FRE  = 1_000_000,
   parameter int  INSTR_W   = 16,
   parameter int  MAX_BYTES = 4,
   parameter int  CS_GAP    = 2,
   localparam int LEN_W     = $clog2(MAX_BYTES + 1),
   localparam int DATA_W    = 8 * MAX_BYTES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               user_wr_en,
   input  logic               user_rd_en,
   input  logic [INSTR_W-2:0] user_addr,
   input  logic [LEN_W-1:0]   user_len,
   input  logic [DATA_W-1:0]  user_wr_data,
   output logic [DATA_W-1:0]  user_rd_data,
   output logic               user_op_busy,
   output logic               user_wr_vild,
   output logic               user_rd_vild,
   output logic               scb,
   output logic               sclk,
`ifdef ADI_SPI_4WIRE_EN
   input  logic               sdo,
`endif
   inout  wire                sdio,
   output logic               dir
);

   localparam int DIV     = CLK_FRE / SCLK_FRE;
   localparam int HALF    = DIV / 2;
   localparam int BAUD_W  = $clog2(DIV);
   localparam int SH_W    = INSTR_W + DATA_W;
   localparam int BIT_W   = $clog2(SH_W);
   localparam int GAP_CYC = CS_GAP * DIV;
   localparam int GAP_W   = $clog2(GAP_CYC + 1);
`ifdef ADI_SPI_4WIRE_EN
   localparam bit FOUR_WIRE = 1'b1;
`else
   localparam bit FOUR_WIRE = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, INSTR, DATA, GAP} state_t;

   state_t             state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [SH_W-1:0]    tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic [LEN_W-1:0]   len_q, len_d, len_c;
   logic               rw_q, rw_d;
   logic               scb_q, scb_d;
   logic               sclk_q, sclk_d;
   logic               dir_q, dir_d;
   logic               wr_vild_q, wr_vild_d;
   logic               rd_vild_q, rd_vild_d;
   logic [1:0]         sync_q;
   logic               miso;
   logic               baud_end;

`ifdef ADI_SPI_4WIRE_EN
   assign miso = sdo;
`else
   assign miso = sdio;
`endif

   // Out-of-range lengths are clamped rather than rejected so a request always produces a frame.
   always_comb begin
      len_c = user_len;
      if (user_len == '0) begin
         len_c = LEN_W'(1);
      end else if (int'(user_len) > MAX_BYTES) begin
         len_c = LEN_W'(MAX_BYTES);
      end
   end

   assign baud_end = (baud_q == BAUD_W'(DIV - 1));

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      len_d     = len_q;
      rw_d      = rw_q;
      scb_d     = scb_q;
      sclk_d    = sclk_q;
      dir_d     = dir_q;
      wr_vild_d = 1'b0;
      rd_vild_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (user_wr_en || user_rd_en) begin
               state_d = INSTR;
               rw_d    = ~user_wr_en;
               len_d   = len_c;
               // Active bytes are moved to the top so the highest active byte leaves first.
               tx_d    = {~user_wr_en, user_addr,
                          user_wr_data << (8 * (MAX_BYTES - int'(len_c)))};
               rx_d    = '0;
               baud_d  = '0;
               bit_d   = BIT_W'(INSTR_W - 1);
               scb_d   = 1'b0;
               sclk_d  = 1'b0;
               dir_d   = 1'b1;
            end
         end
         INSTR, DATA: begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
            if (baud_q == BAUD_W'(HALF - 1)) begin
               sclk_d = 1'b1;
            end
            if (state_q == DATA && rw_q && baud_q == BAUD_W'(HALF + 1)) begin
               rx_d = {rx_q[DATA_W-2:0], sync_q[1]};
            end
            if (baud_end) begin
               sclk_d = 1'b0;
               tx_d   = tx_q << 1;
               if (bit_q != '0) begin
                  bit_d = bit_q - BIT_W'(1);
               end else if (state_q == INSTR) begin
                  state_d = DATA;
                  bit_d   = BIT_W'(8 * int'(len_q) - 1);
                  if (rw_q && !FOUR_WIRE) begin
                     dir_d = 1'b0;
                  end
               end else begin
                  state_d   = GAP;
                  scb_d     = 1'b1;
                  dir_d     = 1'b0;
                  gap_d     = GAP_W'(GAP_CYC - 1);
                  wr_vild_d = ~rw_q;
                  rd_vild_d = rw_q;
                  if (rw_q) begin
                     rd_data_d = rx_d;
                  end
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rd_data_q <= '0;
         len_q     <= '0;
         rw_q      <= 1'b0;
         scb_q     <= 1'b1;
         sclk_q    <= 1'b0;
         dir_q     <= 1'b0;
         wr_vild_q <= 1'b0;
         rd_vild_q <= 1'b0;
         sync_q    <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         len_q     <= len_d;
         rw_q      <= rw_d;
         scb_q     <= scb_d;
         sclk_q    <= sclk_d;
         dir_q     <= dir_d;
         wr_vild_q <= wr_vild_d;
         rd_vild_q <= rd_vild_d;
         sync_q    <= {sync_q[0], miso};
      end
   end

   assign sdio         = dir_q ? tx_q[SH_W-1] : 1'bz;
   assign dir          = dir_q;
   assign scb          = scb_q;
   assign sclk         = sclk_q;
   assign user_rd_data = rd_data_q;
   assign user_wr_vild = wr_vild_q;
   assign user_rd_vild = rd_vild_q;
   assign user_op_busy = (state_q != IDLE);

endmodule

// File: tb/tb_adi_spi_master_param.sv
// Directed bench for adi_spi_master_param (DIV=8, 16-bit instruction, 4-byte bursts) with an SPI slave model.
`timescale 1ns/1ps
module tb_adi_spi_master_param;
   localparam int INSTR_W = 16;
   localparam int MAXB    = 4;
   localparam int DIVV    = 8;
   localparam int CSG     = 2;
`ifdef ADI_SPI_4WIRE_EN
   localparam bit FOUR = 1'b1;
`else
   localparam bit FOUR = 1'b0;
`endif

   typedef struct {
      logic        rd;
      logic [14:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
      int          elen;
      logic [31:0] resp;
      logic [15:0] e_instr;
      logic [31:0] e_bits;
      int          e_rise;
      logic [31:0] e_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [14:0] addr = '0;
   logic [2:0]  len = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rd_data;
   logic        busy, wr_vild, rd_vild, scb, sclk, dir;
   wire         sdio;

   logic        slave_oe = 1'b0, slave_bit = 1'b0;
   int          rise_base = 0, slave_len = 0;
   logic        slave_en = 1'b0;
   logic [31:0] slave_resp = '0;

   int          n_vec = 0, n_err = 0;
   int          n_rise = 0, n_dirlo = 0, n_wrv = 0, n_rdv = 0, n_badv = 0;
   int          hi_run = 0, last_hi = 0;
   logic [63:0] cap = '0;
   logic [31:0] rd_at_vild = '0;
   vec_t        vecs[8];

   always #5 clk = ~clk;

`ifdef ADI_SPI_4WIRE_EN
   logic sdo_w;
   assign sdo_w = slave_oe & slave_bit;
`else
   assign sdio = slave_oe ? slave_bit : 1'bz;
`endif

   adi_spi_master_param #(
      .CLK_FRE(DIVV), .SCLK_FRE(1), .INSTR_W(INSTR_W), .MAX_BYTES(MAXB), .CS_GAP(CSG)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .user_wr_en(wr_en), .user_rd_en(rd_en),
      .user_addr(addr), .user_len(len), .user_wr_data(wdata),
      .user_rd_data(rd_data), .user_op_busy(busy),
      .user_wr_vild(wr_vild), .user_rd_vild(rd_vild),
      .scb(scb), .sclk(sclk),
`ifdef ADI_SPI_4WIRE_EN
      .sdo(sdo_w),
`endif
      .sdio(sdio), .dir(dir)
   );

   // Slave presents read data after each falling sclk during the data phase.
   always @(negedge sclk or posedge scb) begin
      int k;
      k = n_rise - rise_base - INSTR_W;
      if (!scb && slave_en && k >= 0 && k < 8 * slave_len) begin
         slave_bit = slave_resp[8 * slave_len - 1 - k];
         slave_oe  = 1'b1;
      end else begin
         slave_oe  = 1'b0;
      end
   end

   always @(posedge sclk) begin
      cap = {cap[62:0], sdio};
      n_rise++;
      if (!dir) n_dirlo++;
   end

   always @(negedge clk) begin
      if (wr_vild) n_wrv++;
      if (rd_vild) begin
         n_rdv++;
         rd_at_vild = rd_data;
      end
      if ((wr_vild || rd_vild) && (!scb || sclk)) n_badv++;
      if (scb) begin
         hi_run++;
      end else begin
         if (hi_run > 0) last_hi = hi_run;
         hi_run = 0;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_done"}, 64'(t < 2000), 64'd1);
   endtask

   task automatic issue(input logic w, input logic r, input logic [14:0] a,
                        input logic [2:0] l, input logic [31:0] d);
      @(negedge clk);
      wr_en = w; rd_en = r; addr = a; len = l; wdata = d;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          b_rise, b_dirlo, b_wrv, b_rdv, b_badv;
      logic [63:0] c, mask, eb;
      string       tag;
      tag = $sformatf("v%0d", idx);
      b_rise = n_rise; b_dirlo = n_dirlo; b_wrv = n_wrv; b_rdv = n_rdv; b_badv = n_badv;
      rise_base = n_rise; slave_len = v.elen; slave_resp = v.resp; slave_en = v.rd;
      issue(!v.rd, v.rd, v.addr, v.len, v.wdata);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_scb_low"}, 64'(scb), 64'd0);
      wait_idle(tag);
      c    = cap;
      mask = (64'd1 << (8 * v.elen)) - 64'd1;
      eb   = (v.rd && FOUR) ? 64'd0 : 64'(v.e_bits);
      chk({tag, "_sclk_rises"}, 64'(n_rise - b_rise), 64'(v.e_rise));
      chk({tag, "_instr"}, 64'(16'(c >> (8 * v.elen))), 64'(v.e_instr));
      chk({tag, "_data_bits"}, c & mask, eb);
      chk({tag, "_wr_vild"}, 64'(n_wrv - b_wrv), 64'(!v.rd));
      chk({tag, "_rd_vild"}, 64'(n_rdv - b_rdv), 64'(v.rd));
      chk({tag, "_dir_low_rises"}, 64'(n_dirlo - b_dirlo), (v.rd && !FOUR) ? 64'(8 * v.elen) : 64'd0);
      chk({tag, "_vild_frame_end"}, 64'(n_badv - b_badv), 64'd0);
      if (v.rd) begin
         chk({tag, "_rd_at_vild"}, 64'(rd_at_vild), 64'(v.e_rd));
         chk({tag, "_rd_hold"}, 64'(rd_data), 64'(v.e_rd));
      end
   endtask

   initial begin
      int b_wrv, b_rdv, b_rise, b_badv, t;
      //           rd    addr      len   wdata         elen resp          instr     bits          rise rd
      vecs[0] = '{1'b0, 15'h0014, 3'd2, 32'h0000A55A, 2,   32'h0,        16'h0014, 32'h0000A55A, 32,  32'h0};
      vecs[1] = '{1'b1, 15'h0003, 3'd1, 32'h0,        1,   32'h000000C3, 16'h8003, 32'h000000C3, 24,  32'h000000C3};
      vecs[2] = '{1'b1, 15'h0005, 3'd4, 32'h0,        4,   32'h12345678, 16'h8005, 32'h12345678, 48,  32'h12345678};
      vecs[3] = '{1'b0, 15'h7FFF, 3'd0, 32'h1234563C, 1,   32'h0,        16'h7FFF, 32'h0000003C, 24,  32'h0};
      vecs[4] = '{1'b0, 15'h1234, 3'd7, 32'hDEADBEEF, 4,   32'h0,        16'h1234, 32'hDEADBEEF, 48,  32'h0};
      vecs[5] = '{1'b0, 15'h0001, 3'd3, 32'hFFABCDEF, 3,   32'h0,        16'h0001, 32'h00ABCDEF, 40,  32'h0};
      vecs[6] = '{1'b1, 15'h7F00, 3'd2, 32'h0,        2,   32'h00008001, 16'hFF00, 32'h00008001, 32,  32'h00008001};
      vecs[7] = '{1'b1, 15'h0010, 3'd0, 32'h0,        1,   32'h0000005A, 16'h8010, 32'h0000005A, 24,  32'h0000005A};

      repeat (3) @(negedge clk);
      chk("rst_scb", 64'(scb), 64'd1);
      chk("rst_sclk", 64'(sclk), 64'd0);
      chk("rst_dir", 64'(dir), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_vild", 64'({wr_vild, rd_vild}), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Simultaneous write+read, then a write while busy: only the write frame may appear.
      b_wrv = n_wrv; b_rdv = n_rdv; b_rise = n_rise;
      slave_en = 1'b0; rise_base = n_rise;
      issue(1'b1, 1'b1, 15'h0042, 3'd1, 32'h99);
      repeat (30) @(negedge clk);
      wr_en = 1'b1; addr = 15'h0011;
      @(negedge clk);
      wr_en = 1'b0;
      wait_idle("dual");
      repeat (40) @(negedge clk);
      chk("dual_wr_vild", 64'(n_wrv - b_wrv), 64'd1);
      chk("dual_rd_vild", 64'(n_rdv - b_rdv), 64'd0);
      chk("dual_rises", 64'(n_rise - b_rise), 64'd24);
      chk("dual_instr", 64'(16'(cap >> 8)), 64'h0042);
      chk("dual_data", cap & 64'hFF, 64'h99);
      chk("dual_busy", 64'(busy), 64'd0);

      // Back-to-back: request in the first cycle busy is low.
      b_wrv = n_wrv;
      issue(1'b1, 1'b0, 15'h0020, 3'd1, 32'h11);
      wait_idle("b2b_a");
      wr_en = 1'b1; addr = 15'h0021; len = 3'd1; wdata = 32'h22;
      @(negedge clk);
      wr_en = 1'b0;
      chk("b2b_accept", 64'(busy), 64'd1);
      wait_idle("b2b_b");
      chk("b2b_scb_gap", 64'(last_hi), 64'(CSG * DIVV + 1));
      chk("b2b_wr_vild", 64'(n_wrv - b_wrv), 64'd2);
      chk("b2b_data", cap & 64'hFF, 64'h22);

      // Reset while sclk is high on data bit 5 of a write.
      b_wrv = n_wrv; b_rdv = n_rdv; b_badv = n_badv;
      slave_en = 1'b0; rise_base = n_rise;
      issue(1'b1, 1'b0, 15'h0033, 3'd2, 32'hBEEF);
      t = 0;
      while ((n_rise - rise_base) < INSTR_W + 6 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("abort_reach", 64'(t < 1000), 64'd1);
      chk("abort_pre_sclk", 64'(sclk), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_scb", 64'(scb), 64'd1);
      chk("abort_sclk", 64'(sclk), 64'd0);
      chk("abort_dir", 64'(dir), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rd_data", 64'(rd_data), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_vild", 64'((n_wrv - b_wrv) + (n_rdv - b_rdv)), 64'd0);
      run_vec(vecs[0], 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
